apb_master_mux: RTL and testbench

Parametrised APB4 master with integrated slave decode, per-slave response muxing and an access timeout. Sits between the AXI4-Lite front end and up to 16 APB slaves. Takes one captured request at a time and drives a registered Setup/Access sequence. Returns one-cycle-pulsed read data and response status to the front end.

---
 rtl/apb_master_mux.sv | 117 +++++++++++
 tb/tb_apb_master_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_mux.sv
// apb_master_mux: APB4 master with slave decode, per-slave response mux and access timeout; S* = front-end request/response, P* = APB bus, Out_State = FSM state
module apb_master_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     STREQ,
  output logic                     SRDY,
  input  logic                     SWRT,
  input  logic [31:0]              SADDR,
  input  logic [31:0]              SWDATA,
  input  logic [3:0]               WSTRB,
  input  logic [2:0]               SPROT,
  output logic                     SDONE,
  output logic [31:0]              SRDATA,
  output logic [1:0]               SRESP,
  output logic                     STIMEOUT,
  output logic [31:0]              PADDR,
  output logic [2:0]               PPROT,
  output logic [NUM_SLAVES-1:0]    PSELx,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  output logic [1:0]               Out_State
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DECERR = 2'd3} state_t;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  state_t state;
  logic [3:0] idx;
  logic [31:0] wait_cnt;
  logic [3:0] req_idx;
  logic [15:0] req_sel, rdy16, err16;
  logic [511:0] rd512;
  logic hit, sel_rdy, sel_err, timed_out;
  logic [31:0] sel_rdata;
  // Slave vectors are widened to 16 entries so the 4-bit registered index can select without range issues
  assign req_idx = SADDR[SEL_LSB+3:SEL_LSB];
  assign hit = {1'b0, req_idx} < 5'(NUM_SLAVES);
  assign req_sel = 16'd1 << req_idx;
  assign rdy16 = 16'(PREADY);
  assign err16 = 16'(PSLVERR);
  assign rd512 = 512'(PRDATA);
  assign sel_rdy = rdy16[idx];
  assign sel_err = err16[idx];
  assign sel_rdata = rd512[{idx, 5'd0} +: 32];
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign SRDY = state == IDLE;
  assign Out_State = state;
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      idx <= '0;
      wait_cnt <= '0;
      PSELx <= '0;
      PENABLE <= 1'b0;
      PADDR <= '0;
      PWDATA <= '0;
      PSTRB <= '0;
      PPROT <= '0;
      PWRITE <= 1'b0;
      SDONE <= 1'b0;
      SRESP <= 2'b00;
      SRDATA <= '0;
      STIMEOUT <= 1'b0;
    end else begin
      SDONE <= 1'b0;
      SRESP <= 2'b00;
      SRDATA <= '0;
      STIMEOUT <= 1'b0;
      case (state)
        IDLE: if (STREQ) begin
          PWRITE <= SWRT;
          PADDR <= SADDR;
          PWDATA <= SWDATA;
          PSTRB <= SWRT ? WSTRB : 4'b0000;
          PPROT <= SPROT;
          idx <= req_idx;
          PSELx <= hit ? req_sel[NUM_SLAVES-1:0] : '0;
          state <= hit ? SETUP : DECERR;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          wait_cnt <= '0;
          state <= ACCESS;
        end
        ACCESS: if (sel_rdy) begin
          state <= IDLE;
          PSELx <= '0;
          PENABLE <= 1'b0;
          SDONE <= 1'b1;
          SRESP <= sel_err ? 2'b10 : 2'b00;
          SRDATA <= PWRITE ? 32'd0 : sel_rdata;
        end else if (timed_out) begin
          state <= IDLE;
          PSELx <= '0;
          PENABLE <= 1'b0;
          SDONE <= 1'b1;
          SRESP <= 2'b10;
          STIMEOUT <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
        DECERR: begin
          state <= IDLE;
          SDONE <= 1'b1;
          SRESP <= 2'b11;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_mux.sv
// tb_apb_master_mux: directed table, random transactions against a transaction-level model, reset and no-timeout sequences
module tb_apb_master_mux;
  localparam int TO = 8;
  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;
    int w; logic err; logic [31:0] rdata; logic noise;
    logic [3:0] exp_sel; logic [1:0] exp_resp; logic [31:0] exp_rdata; logic exp_to; int exp_lat;
  } vec_t;
  logic PCLK = 0, PRESET, STREQ, STREQ_b, SWRT;
  logic [31:0] SADDR, SWDATA;
  logic [3:0] WSTRB;
  logic [2:0] SPROT;
  logic [3:0] PREADY, PREADY_b, PSLVERR;
  logic [127:0] PRDATA;
  logic SRDY, SDONE, STIMEOUT, PENABLE, PWRITE;
  logic [31:0] SRDATA, PADDR, PWDATA;
  logic [1:0] SRESP, Out_State;
  logic [2:0] PPROT;
  logic [3:0] PSELx, PSTRB;
  logic b_SRDY, b_SDONE, b_STIMEOUT, b_PENABLE, b_PWRITE;
  logic [31:0] b_SRDATA, b_PADDR, b_PWDATA;
  logic [1:0] b_SRESP, b_Out_State;
  logic [2:0] b_PPROT;
  logic [3:0] b_PSELx, b_PSTRB;
  int n_chk, n_fail, cur;
  vec_t tbl[8];
  always #5 PCLK = ~PCLK;
  apb_master_mux #(.NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .STREQ(STREQ), .SRDY(SRDY), .SWRT(SWRT), .SADDR(SADDR),
    .SWDATA(SWDATA), .WSTRB(WSTRB), .SPROT(SPROT), .SDONE(SDONE), .SRDATA(SRDATA), .SRESP(SRESP),
    .STIMEOUT(STIMEOUT), .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .Out_State(Out_State));
  apb_master_mux #(.NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT(0)) dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .STREQ(STREQ_b), .SRDY(b_SRDY), .SWRT(SWRT), .SADDR(SADDR),
    .SWDATA(SWDATA), .WSTRB(WSTRB), .SPROT(SPROT), .SDONE(b_SDONE), .SRDATA(b_SRDATA), .SRESP(b_SRESP),
    .STIMEOUT(b_STIMEOUT), .PADDR(b_PADDR), .PPROT(b_PPROT), .PSELx(b_PSELx), .PENABLE(b_PENABLE),
    .PWRITE(b_PWRITE), .PWDATA(b_PWDATA), .PSTRB(b_PSTRB), .PREADY(PREADY_b), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .Out_State(b_Out_State));
  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL txn%0d %s: got %0h expected %0h", cur, nm, act, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    int s = int'(v.addr[15:12]);
    if (s >= 4) begin
      m.exp_sel = 0; m.exp_resp = 2'b11; m.exp_rdata = 0; m.exp_to = 0; m.exp_lat = 2;
    end else begin
      m.exp_sel = 4'(1 << s);
      if (v.w + 1 > TO) begin
        m.exp_resp = 2'b10; m.exp_rdata = 0; m.exp_to = 1; m.exp_lat = 2 + TO;
      end else begin
        m.exp_resp = v.err ? 2'b10 : 2'b00; m.exp_rdata = v.wr ? 32'd0 : v.rdata; m.exp_to = 0; m.exp_lat = 3 + v.w;
      end
    end
    return m;
  endfunction
  task automatic drive_slaves(input vec_t v, input int r, input bit rnd);
    int s = int'(v.addr[15:12]);
    for (int i = 0; i < 4; i++) begin
      PRDATA[32*i +: 32] = $urandom;
      PREADY[i] = v.noise ? 1'b1 : (rnd ? 1'($urandom) : 1'b0);
      PSLVERR[i] = v.noise ? 1'b1 : (rnd ? 1'($urandom) : 1'b0);
    end
    if (s < 4) begin
      PRDATA[32*s +: 32] = v.rdata;
      PREADY[s] = (r == v.w + 2) || (r == 1 && rnd && 1'($urandom));
      PSLVERR[s] = v.err;
    end
  endtask
  task automatic run_txn(input vec_t v, input bit rnd);
    chk("srdy_before_accept", SRDY, 1'b1);
    STREQ = 1; SWRT = v.wr; SADDR = v.addr; SWDATA = v.wdata; WSTRB = v.strb; SPROT = v.prot;
    drive_slaves(v, 0, rnd);
    tick;
    STREQ = 0; SWRT = 1'($urandom); SADDR = $urandom; SWDATA = $urandom; WSTRB = 4'($urandom); SPROT = 3'($urandom);
    chk("state_after_accept", Out_State, v.exp_sel == 0 ? 2'd3 : 2'd1);
    chk("psel_setup", PSELx, v.exp_sel);
    chk("penable_setup", PENABLE, 1'b0);
    chk("paddr", PADDR, v.addr);
    chk("pwdata", PWDATA, v.wdata);
    chk("pstrb", PSTRB, v.wr ? v.strb : 4'h0);
    chk("pprot", PPROT, v.prot);
    chk("pwrite", PWRITE, v.wr);
    chk("sdone_setup", SDONE, 1'b0);
    chk("sresp_setup", SRESP, 2'b00);
    for (int r = 1; r < v.exp_lat; r++) begin
      drive_slaves(v, r, rnd);
      tick;
      if (r + 1 < v.exp_lat) begin
        chk("state_access", Out_State, 2'd2);
        chk("psel_access", PSELx, v.exp_sel);
        chk("penable_access", PENABLE, 1'b1);
        chk("sdone_access", SDONE, 1'b0);
        chk("stimeout_access", STIMEOUT, 1'b0);
      end else begin
        chk("state_done", Out_State, 2'd0);
        chk("srdy_done", SRDY, 1'b1);
        chk("psel_done", PSELx, 4'h0);
        chk("penable_done", PENABLE, 1'b0);
        chk("sdone", SDONE, 1'b1);
        chk("sresp", SRESP, v.exp_resp);
        chk("srdata", SRDATA, v.exp_rdata);
        chk("stimeout", STIMEOUT, v.exp_to);
      end
    end
  endtask
  initial begin
    vec_t v;
    int nd;
    n_chk = 0; n_fail = 0; cur = 0;
    PRESET = 1; STREQ = 0; STREQ_b = 0; SWRT = 0; SADDR = 0; SWDATA = 0; WSTRB = 0; SPROT = 0;
    PREADY = 0; PREADY_b = 0; PSLVERR = 0; PRDATA = 0;
    tick; tick;
    chk("rst_state", Out_State, 2'd0);
    chk("rst_psel", PSELx, 4'h0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_sdone", SDONE, 1'b0);
    chk("rst_sresp", SRESP, 2'b00);
    chk("rst_stimeout", STIMEOUT, 1'b0);
    chk("rst_srdata", SRDATA, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pstrb", PSTRB, 4'h0);
    chk("rst_pprot", PPROT, 3'd0);
    chk("rst_pwrite", PWRITE, 1'b0);
    PRESET = 0;
    tick;
    chk("srdy_after_reset", SRDY, 1'b1);
    tbl[0] = '{1'b1, 32'h0000_2010, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 1'b0, 4'b0100, 2'b00, 32'h0, 1'b0, 3};
    tbl[1] = '{1'b0, 32'h0000_1000, 32'h1111_2222, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 1'b0, 4'b0010, 2'b00, 32'h1234_5678, 1'b0, 6};
    tbl[2] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 3'd1, 0, 1'b1, 32'hAAAA_5555, 1'b0, 4'b0001, 2'b10, 32'hAAAA_5555, 1'b0, 3};
    tbl[3] = '{1'b1, 32'h0000_0008, 32'h0F0F_0F0F, 4'h5, 3'd7, 2, 1'b0, 32'h9999_9999, 1'b1, 4'b0001, 2'b00, 32'h0, 1'b0, 5};
    tbl[4] = '{1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h7777_7777, 1'b0, 4'b0000, 2'b11, 32'h0, 1'b0, 2};
    tbl[5] = '{1'b0, 32'h0000_3FFC, 32'h0, 4'h0, 3'd4, 20, 1'b0, 32'h5555_AAAA, 1'b0, 4'b1000, 2'b10, 32'h0, 1'b1, 10};
    tbl[6] = '{1'b1, 32'h8000_F000, 32'hCAFE_0001, 4'h3, 3'd3, 0, 1'b0, 32'h0, 1'b0, 4'b0000, 2'b11, 32'h0, 1'b0, 2};
    tbl[7] = '{1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'd5, 7, 1'b0, 32'h0BAD_F00D, 1'b0, 4'b1000, 2'b00, 32'h0BAD_F00D, 1'b0, 10};
    foreach (tbl[i]) begin
      cur = i;
      run_txn(tbl[i], 1'b0);
    end
    for (int i = 0; i < 150; i++) begin
      cur = 100 + i;
      v.wr = 1'($urandom); v.addr = {16'($urandom), 4'($urandom_range(0, 7)), 12'($urandom)};
      v.wdata = $urandom; v.strb = 4'($urandom); v.prot = 3'($urandom); v.w = $urandom_range(0, 10);
      v.err = 1'($urandom); v.rdata = $urandom; v.noise = 1'b0;
      v = model(v);
      run_txn(v, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < $urandom_range(1, 2); g++) begin
          PREADY = 4'($urandom); PSLVERR = 4'($urandom);
          tick;
          chk("idle_sdone", SDONE, 1'b0);
          chk("idle_state", Out_State, 2'd0);
        end
      end
    end
    cur = 900;
    PREADY = 0; PSLVERR = 0;
    STREQ = 1; SWRT = 0; SADDR = 32'h0000_2000;
    tick;
    STREQ = 0;
    tick; tick;
    chk("pre_reset_state", Out_State, 2'd2);
    PRESET = 1;
    tick;
    PRESET = 0;
    chk("midrst_state", Out_State, 2'd0);
    chk("midrst_psel", PSELx, 4'h0);
    chk("midrst_penable", PENABLE, 1'b0);
    chk("midrst_sdone", SDONE, 1'b0);
    chk("midrst_paddr", PADDR, 32'd0);
    tick;
    chk("midrst_srdy", SRDY, 1'b1);
    chk("midrst_no_sdone", SDONE, 1'b0);
    cur = 901;
    SADDR = 32'h0000_1000; SWRT = 0; PREADY_b = 0; STREQ_b = 1;
    tick;
    STREQ_b = 0;
    nd = 0;
    for (int i = 0; i < 1000; i++) begin
      tick;
      if (b_SDONE) nd++;
    end
    chk("no_to_sdones", nd, 0);
    chk("no_to_state", b_Out_State, 2'd2);
    chk("no_to_penable", b_PENABLE, 1'b1);
    PRDATA[63:32] = 32'hCAFE_F00D; PREADY_b = 4'b0010;
    tick;
    PREADY_b = 0;
    chk("no_to_sdone", b_SDONE, 1'b1);
    chk("no_to_sresp", b_SRESP, 2'b00);
    chk("no_to_srdata", b_SRDATA, 32'hCAFE_F00D);
    chk("no_to_stimeout", b_STIMEOUT, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
